// File: rtl/ast_rr_arbiter.sv
// ast_rr_arbiter: packet-atomic round-robin merge of RX_DIR Avalon-ST inputs
// onto one Avalon-ST output. A granted packet owns the output until its
// endofpacket beat is accepted. Every packet costs one IDLE arbitration cycle.
// The output is a zero-latency combinational pass-through of the granted port.
module ast_rr_arbiter #(
   parameter int DATA_WIDTH    = 64,
   parameter int CHANNEL_WIDTH = 8,
   parameter int EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8),
   parameter int RX_DIR        = 4,
   parameter int DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [RX_DIR*DATA_WIDTH-1:0]      ast_data_i,
   input  logic [RX_DIR-1:0]                 ast_startofpacket_i,
   input  logic [RX_DIR-1:0]                 ast_endofpacket_i,
   input  logic [RX_DIR-1:0]                 ast_valid_i,
   input  logic [RX_DIR*EMPTY_WIDTH-1:0]     ast_empty_i,
   input  logic [RX_DIR*CHANNEL_WIDTH-1:0]   ast_channel_i,
   output logic [RX_DIR-1:0]                 ast_ready_o,
   output logic [DATA_WIDTH-1:0]             ast_data_o,
   output logic                              ast_startofpacket_o,
   output logic                              ast_endofpacket_o,
   output logic                              ast_valid_o,
   output logic [EMPTY_WIDTH-1:0]            ast_empty_o,
   output logic [CHANNEL_WIDTH-1:0]          ast_channel_o,
   output logic [DIR_SEL_WIDTH-1:0]          dir_o,
   input  logic                              ast_ready_i
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                   state, state_nxt;
   logic [DIR_SEL_WIDTH-1:0] grant, grant_nxt;
   logic [DIR_SEL_WIDTH-1:0] last, last_nxt;
   logic [DIR_SEL_WIDTH-1:0] winner;
   logic                     found;

   // Port visited at step 'off' of a scan that starts just after 'base'.
   function automatic int scan_idx(input int base, input int off);
      return (base + 1 + off) % RX_DIR;
   endfunction

   // Round-robin scan for the first valid SOP beat after the last winner.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      found  = 1'b0;
      winner = '0;
      for (int i = 0; i < RX_DIR; i++) begin
         if (!found && ast_valid_i[scan_idx(int'(last), i)]
                    && ast_startofpacket_i[scan_idx(int'(last), i)]) begin
            found  = 1'b1;
            winner = DIR_SEL_WIDTH'(scan_idx(int'(last), i));
         end
      end
   end

   // State register; reset makes the first scan start at port 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
         state <= IDLE;
         grant <= '0;
         last  <= DIR_SEL_WIDTH'(RX_DIR - 1);
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         last  <= last_nxt;
      end
   end

   // Next state: grant in IDLE, release after the accepted EOP beat in BUSY.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = BUSY;
               grant_nxt = winner;
               last_nxt  = winner;
            end
         end
         BUSY: begin
            if (ast_valid_i[grant] && ast_ready_i && ast_endofpacket_i[grant])
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output mux: pass the granted port through in BUSY, drive zeros in IDLE.
   always_comb begin
      ast_ready_o         = '0;
      ast_data_o          = '0;
      ast_startofpacket_o = 1'b0;
      ast_endofpacket_o   = 1'b0;
      ast_valid_o         = 1'b0;
      ast_empty_o         = '0;
      ast_channel_o       = '0;
      dir_o               = last;
      if (state == BUSY) begin
         ast_ready_o[grant]  = ast_ready_i;
         ast_data_o          = ast_data_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
         ast_startofpacket_o = ast_startofpacket_i[grant];
         ast_endofpacket_o   = ast_endofpacket_i[grant];
         ast_valid_o         = ast_valid_i[grant];
         ast_empty_o         = ast_empty_i[int'(grant)*EMPTY_WIDTH +: EMPTY_WIDTH];
         ast_channel_o       = ast_channel_i[int'(grant)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
         dir_o               = grant;
      end
   end

endmodule

// File: tb/tb_ast_rr_arbiter.sv
// Directed self-checking bench for ast_rr_arbiter (4 ports, 64-bit data).
// Inputs change 1 time unit after posedge; outputs are compared 1 unit later.
module tb_ast_rr_arbiter;

   localparam int DW = 64;
   localparam int CW = 8;
   localparam int EW = 3;
   localparam int N  = 4;
   localparam int SW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*DW-1:0] data_i;
   logic [N-1:0]    sop_i, eop_i, valid_i;
   logic [N*EW-1:0] empty_i;
   logic [N*CW-1:0] channel_i;
   logic [N-1:0]    ready_o;
   logic [DW-1:0]   data_o;
   logic            sop_o, eop_o, valid_o;
   logic [EW-1:0]   empty_o;
   logic [CW-1:0]   channel_o;
   logic [SW-1:0]   dir_o;
   logic            ready_i;

   int n_cmp = 0;
   int n_err = 0;

   ast_rr_arbiter #(
      .DATA_WIDTH(DW), .CHANNEL_WIDTH(CW), .EMPTY_WIDTH(EW), .RX_DIR(N), .DIR_SEL_WIDTH(SW)
   ) dut (
      .clk(clk), .rst(rst),
      .ast_data_i(data_i), .ast_startofpacket_i(sop_i), .ast_endofpacket_i(eop_i),
      .ast_valid_i(valid_i), .ast_empty_i(empty_i), .ast_channel_i(channel_i),
      .ast_ready_o(ready_o), .ast_data_o(data_o), .ast_startofpacket_o(sop_o),
      .ast_endofpacket_o(eop_o), .ast_valid_o(valid_o), .ast_empty_o(empty_o),
      .ast_channel_o(channel_o), .dir_o(dir_o), .ast_ready_i(ready_i)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      data_i = '0; sop_i = '0; eop_i = '0; valid_i = '0; empty_i = '0; channel_i = '0;
   endtask

   task automatic drive_port(input int k, input logic v, input logic s, input logic e,
                             input logic [DW-1:0] d, input logic [EW-1:0] em,
                             input logic [CW-1:0] ch);
      valid_i[k] = v; sop_i[k] = s; eop_i[k] = e;
      data_i[k*DW +: DW] = d; empty_i[k*EW +: EW] = em; channel_i[k*CW +: CW] = ch;
   endtask

   // Leaves the DUT in IDLE with last=3, one time unit after a posedge.
   task automatic reset_dut();
      rst = 1'b1;
      clear_inputs();
      ready_i = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++; if (ready_o !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", ready_o); end
      n_cmp++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
      n_cmp++; if (dir_o !== 2'd3) begin n_err++; $display("FAIL reset_dir: got %0d expected 3", dir_o); end
      tick(); tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (data_o !== 64'd0 || sop_o !== 1'b0 || eop_o !== 1'b0) begin
         n_err++; $display("FAIL idle_fields: got data %0h sop %b eop %b expected zeros", data_o, sop_o, eop_o);
      end
      tick();
   endtask

   task automatic test_single_port();
      logic [DW-1:0] exp_d [3] = '{64'hA1, 64'hA2, 64'hA3};
      reset_dut();
      // Bubble cycle: request visible, nothing passed yet.
      drive_port(2, 1'b1, 1'b1, 1'b0, exp_d[0], 3'd0, 8'h17);
      #1;
      n_cmp++; if (valid_o !== 1'b0 || ready_o !== 4'b0000) begin
         n_err++; $display("FAIL sp_bubble: got valid %b ready %b expected 0 0000", valid_o, ready_o);
      end
      tick();
      for (int b = 0; b < 3; b++) begin
         drive_port(2, 1'b1, b == 0, b == 2, exp_d[b], (b == 2) ? 3'd5 : 3'd0, 8'h17);
         #1;
         n_cmp++; if (valid_o !== 1'b1 || data_o !== exp_d[b]) begin
            n_err++; $display("FAIL sp_beat%0d: got valid %b data %0h expected 1 %0h", b, valid_o, data_o, exp_d[b]);
         end
         n_cmp++; if (sop_o !== (b == 0) || eop_o !== (b == 2) || channel_o !== 8'h17) begin
            n_err++; $display("FAIL sp_flags%0d: got sop %b eop %b ch %0h", b, sop_o, eop_o, channel_o);
         end
         n_cmp++; if (empty_o !== ((b == 2) ? 3'd5 : 3'd0)) begin
            n_err++; $display("FAIL sp_empty%0d: got %0d expected %0d", b, empty_o, (b == 2) ? 5 : 0);
         end
         n_cmp++; if (ready_o !== 4'b0100 || dir_o !== 2'd2) begin
            n_err++; $display("FAIL sp_ready%0d: got ready %b dir %0d expected 0100 2", b, ready_o, dir_o);
         end
         tick();
      end
      clear_inputs();
      #1;
      n_cmp++; if (valid_o !== 1'b0 || dir_o !== 2'd2 || data_o !== 64'd0) begin
         n_err++; $display("FAIL sp_after: got valid %b dir %0d data %0h expected 0 2 0", valid_o, dir_o, data_o);
      end
      tick();
   endtask

   task automatic test_all_ports();
      int beat [N] = '{0, 0, 0, 0};
      int src, bt;
      logic ev;
      reset_dut();
      for (int c = 0; c < 18; c++) begin
         for (int k = 0; k < N; k++)
            drive_port(k, 1'b1, beat[k] == 0, beat[k] == 1, 64'(k*16 + beat[k]), 3'd0, 8'(k));
         #1;
         ev  = (c % 3) != 0;
         src = (c / 3) % 4;
         bt  = (c % 3) - 1;
         n_cmp++; if (valid_o !== ev) begin n_err++; $display("FAIL rr_valid c%0d: got %b expected %b", c, valid_o, ev); end
         n_cmp++; if (ready_o !== (ev ? 4'(1 << src) : 4'b0000)) begin
            n_err++; $display("FAIL rr_ready c%0d: got %b expected src %0d", c, ready_o, src);
         end
         if (ev) begin
            n_cmp++; if (dir_o !== 2'(src) || data_o !== 64'(src*16 + bt) || sop_o !== (bt == 0)) begin
               n_err++; $display("FAIL rr_beat c%0d: got dir %0d data %0h expected %0d %0h", c, dir_o, data_o, src, src*16 + bt);
            end
         end
         for (int k = 0; k < N; k++)
            if (ready_o[k]) beat[k] ^= 1;
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic rdy [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int   exp_b [6] = '{0, 0, 1, 1, 1, 2};
      int   b = 0;
      reset_dut();
      for (int c = 0; c < 7; c++) begin
         // Other ports hold non-SOP beats: never requests, must stay stalled.
         drive_port(0, 1'b1, 1'b0, 1'b0, 64'hDEAD, 3'd0, 8'h0);
         drive_port(2, 1'b1, 1'b0, 1'b0, 64'hDEAD, 3'd0, 8'h0);
         drive_port(3, 1'b1, 1'b0, 1'b0, 64'hDEAD, 3'd0, 8'h0);
         drive_port(1, b < 3, b == 0, b == 2, 64'(256 + b), 3'd0, 8'h1);
         ready_i = (c < 6) ? rdy[c] : 1'b1;
         #1;
         if (c == 0 || c == 6) begin
            n_cmp++; if (valid_o !== 1'b0 || ready_o !== 4'b0000) begin
               n_err++; $display("FAIL bp_idle c%0d: got valid %b ready %b expected 0 0000", c, valid_o, ready_o);
            end
            if (c == 6) begin
               n_cmp++; if (dir_o !== 2'd1) begin n_err++; $display("FAIL bp_last: got %0d expected 1", dir_o); end
            end
         end else begin
            n_cmp++; if (valid_o !== 1'b1 || data_o !== 64'(256 + exp_b[c]) || dir_o !== 2'd1) begin
               n_err++; $display("FAIL bp_beat c%0d: got valid %b data %0h dir %0d expected 1 %0h 1", c, valid_o, data_o, dir_o, 256 + exp_b[c]);
            end
            n_cmp++; if (ready_o !== (rdy[c] ? 4'b0010 : 4'b0000)) begin
               n_err++; $display("FAIL bp_ready c%0d: got %b expected %b", c, ready_o, rdy[c] ? 4'b0010 : 4'b0000);
            end
         end
         if (ready_o[1] && valid_i[1]) b++;
         tick();
      end
      ready_i = 1'b1;
   endtask

   task automatic test_single_beat();
      int src;
      logic ev;
      reset_dut();
      for (int c = 0; c < 8; c++) begin
         drive_port(0, 1'b1, 1'b1, 1'b1, 64'h10, 3'd0, 8'h0);
         drive_port(3, 1'b1, 1'b1, 1'b1, 64'h13, 3'd0, 8'h3);
         #1;
         ev  = (c % 2) == 1;
         src = ((c / 2) % 2 == 1) ? 3 : 0;
         n_cmp++; if (valid_o !== ev || ready_o !== (ev ? 4'(1 << src) : 4'b0000)) begin
            n_err++; $display("FAIL sb c%0d: got valid %b ready %b expected %b src %0d", c, valid_o, ready_o, ev, src);
         end
         if (ev) begin
            n_cmp++; if (dir_o !== 2'(src) || data_o !== 64'(16 + src)) begin
               n_err++; $display("FAIL sb_dir c%0d: got dir %0d data %0h expected %0d %0h", c, dir_o, data_o, src, 16 + src);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid_packet();
      int b = 0;
      reset_dut();
      for (int c = 0; c < 4; c++) begin
         drive_port(3, 1'b1, b == 0, b == 3, 64'(768 + b), 3'd0, 8'h3);
         #1;
         if (c == 3) break;
         if (ready_o[3]) b++;
         tick();
      end
      n_cmp++; if (valid_o !== 1'b1 || data_o !== 64'h302) begin
         n_err++; $display("FAIL rm_pre: got valid %b data %0h expected 1 302", valid_o, data_o);
      end
      #1 rst = 1'b1;
      #1;
      n_cmp++; if (valid_o !== 1'b0 || ready_o !== 4'b0000) begin
         n_err++; $display("FAIL rm_async: got valid %b ready %b expected 0 0000", valid_o, ready_o);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      clear_inputs();
      drive_port(0, 1'b1, 1'b1, 1'b1, 64'hF0, 3'd0, 8'h0);
      drive_port(3, 1'b1, 1'b1, 1'b1, 64'h3F0, 3'd0, 8'h3);
      #1;
      n_cmp++; if (valid_o !== 1'b0 || dir_o !== 2'd3) begin
         n_err++; $display("FAIL rm_idle: got valid %b dir %0d expected 0 3", valid_o, dir_o);
      end
      tick();
      n_cmp++; if (valid_o !== 1'b1 || dir_o !== 2'd0 || data_o !== 64'hF0 || ready_o !== 4'b0001) begin
         n_err++; $display("FAIL rm_first: got valid %b dir %0d data %0h ready %b expected 1 0 f0 0001", valid_o, dir_o, data_o, ready_o);
      end
      tick();
   endtask

   task automatic test_non_sop_idle();
      reset_dut();
      for (int c = 0; c < 3; c++) begin
         drive_port(1, 1'b1, 1'b0, 1'b0, 64'h55, 3'd0, 8'h1);
         #1;
         n_cmp++; if (valid_o !== 1'b0 || ready_o !== 4'b0000 || dir_o !== 2'd3) begin
            n_err++; $display("FAIL nonsop c%0d: got valid %b ready %b dir %0d expected 0 0000 3", c, valid_o, ready_o, dir_o);
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      ready_i = 1'b1;
      clear_inputs();
      test_reset();
      test_single_port();
      test_all_ports();
      test_backpressure();
      test_single_beat();
      test_reset_mid_packet();
      test_non_sop_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
